// File: rtl/cache_pkg.sv
// Shared cache types and geometry helpers for the line-state,
// tag/data arrays and the cache controller.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      WB_WAIT,
      DONE
   } flush_state_t;

   function automatic int sets_f(input int ways, input int total);
      return total / ways;
   endfunction

   function automatic int way_w_f(input int ways);
      return $clog2(ways);
   endfunction

   function automatic int idx_w_f(input int ways, input int total);
      return $clog2(total / ways);
   endfunction

endpackage

// File: rtl/cache_free_way_enc.sv
// Lowest-numbered invalid way of a set, for fill allocation.
// Returns way 0 with o_free_valid low when the set is full.
module cache_free_way_enc #(
   parameter  int WAYS  = 4,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]  i_valid,
   output logic             o_free_valid,
   output logic [WAY_W-1:0] o_free_way
);

   always_comb begin
      o_free_valid = 1'b0;
      o_free_way   = '0;
      // Descending scan so the lowest invalid way is the last writer.
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!i_valid[i]) begin
            o_free_valid = 1'b1;
            o_free_way   = WAY_W'(i);
         end
      end
   end

endmodule

// File: rtl/cache_line_state.sv
// Valid/dirty state per (way, set) with line ops, free-way
// selection and a flush engine feeding the write-back path.
module cache_line_state
   import cache_pkg::*;
#(
   parameter  int WAYS           = 4,
   parameter  int TOTAL_SIZE     = 16,
   parameter  int INVAL_ON_FLUSH = 1,
   localparam int SETS  = sets_f(WAYS, TOTAL_SIZE),
   localparam int WAY_W = way_w_f(WAYS),
   localparam int IDX_W = idx_w_f(WAYS, TOTAL_SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] index,
   input  logic [WAY_W-1:0] way,
   input  logic             we,
   input  logic             set_dirty,
   input  logic             inv,
   input  logic             clean,
   output logic [WAYS-1:0]  valid_out,
   output logic [WAYS-1:0]  dirty_out,
   output logic             free_valid,
   output logic [WAY_W-1:0] free_way,
   output logic             set_full,
   input  logic             flush_req,
   output logic             flush_busy,
   output logic             flush_done,
   output logic             wb_valid,
   output logic [WAY_W-1:0] wb_way,
   output logic [IDX_W-1:0] wb_index,
   input  logic             wb_ready
);

   localparam int PTR_W = IDX_W + WAY_W;

   flush_state_t     r_state;
   flush_state_t     w_state_nxt;
   logic [WAYS-1:0]  r_valid [SETS];
   logic [WAYS-1:0]  r_dirty [SETS];
   logic [PTR_W-1:0] r_ptr;
   logic             r_wb_valid;
   logic [WAY_W-1:0] r_wb_way;
   logic [IDX_W-1:0] r_wb_index;

   logic [IDX_W-1:0] w_ptr_set;
   logic [WAY_W-1:0] w_ptr_way;
   logic             w_last;
   logic             w_hit;
   logic             w_hs;
   logic [WAYS-1:0]  w_valid_set;
   logic             w_free_valid;

   // Pointer is {set, way}, so a plain increment walks way inner.
   assign w_ptr_set = r_ptr[PTR_W-1:WAY_W];
   assign w_ptr_way = r_ptr[WAY_W-1:0];
   assign w_last    = &r_ptr;
   assign w_hit     = r_valid[w_ptr_set][w_ptr_way]
                    & r_dirty[w_ptr_set][w_ptr_way];
   assign w_hs      = (r_state == WB_WAIT) & r_wb_valid & wb_ready;

   assign w_valid_set = r_valid[index];
   assign valid_out   = w_valid_set;
   assign dirty_out   = r_dirty[index];
   assign free_valid  = w_free_valid;
   assign set_full    = ~w_free_valid;

   cache_free_way_enc #(
      .WAYS(WAYS)
   ) u_free_enc (
      .i_valid      (w_valid_set),
      .o_free_valid (w_free_valid),
      .o_free_way   (free_way)
   );

   assign flush_busy = (r_state != IDLE);
   assign flush_done = (r_state == DONE);
   assign wb_valid   = r_wb_valid;
   assign wb_way     = r_wb_way;
   assign wb_index   = r_wb_index;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (flush_req) w_state_nxt = SCAN;
         SCAN: begin
            if (w_hit)       w_state_nxt = WB_WAIT;
            else if (w_last) w_state_nxt = DONE;
         end
         WB_WAIT: if (w_hs) w_state_nxt = w_last ? DONE : SCAN;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
         end
      end else begin
         unique case (r_state)
            IDLE: begin
               if (inv) begin
                  r_valid[index][way] <= 1'b0;
                  r_dirty[index][way] <= 1'b0;
               end else if (we) begin
                  r_valid[index][way] <= 1'b1;
                  r_dirty[index][way] <= set_dirty;
               end else if (clean) begin
                  r_dirty[index][way] <= 1'b0;
               end
            end
            SCAN: begin
               if (!w_hit && INVAL_ON_FLUSH != 0)
                  r_valid[w_ptr_set][w_ptr_way] <= 1'b0;
            end
            WB_WAIT: begin
               if (w_hs) begin
                  r_dirty[w_ptr_set][w_ptr_way] <= 1'b0;
                  if (INVAL_ON_FLUSH != 0)
                     r_valid[w_ptr_set][w_ptr_way] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_wb_valid <= 1'b0;
         r_wb_way   <= '0;
         r_wb_index <= '0;
      end else begin
         unique case (r_state)
            SCAN: begin
               if (w_hit) begin
                  r_wb_valid <= 1'b1;
                  r_wb_way   <= w_ptr_way;
                  r_wb_index <= w_ptr_set;
               end else if (!w_last) begin
                  r_ptr <= r_ptr + PTR_W'(1);
               end
            end
            WB_WAIT: begin
               if (w_hs) begin
                  r_wb_valid <= 1'b0;
                  if (!w_last) r_ptr <= r_ptr + PTR_W'(1);
               end
            end
            default: r_ptr <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_line_state.sv
// Random and directed bench for cache_line_state against a
// per-line valid/dirty table model; two flush-policy instances.
module tb_cache_line_state;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] index, way;
   logic       we, set_dirty, inv, clean, flush_req, wb_ready;

   logic [3:0] a_valid, a_dirty, b_valid, b_dirty;
   logic       a_fv, a_full, a_busy, a_done, a_wbv;
   logic       b_fv, b_full, b_busy, b_done, b_wbv;
   logic [1:0] a_fw, a_wbw, a_wbi, b_fw, b_wbw, b_wbi;

   int n_pass = 0;
   int n_total = 0;

   // model: k=0 flushes invalidate, k=1 flushes keep valid
   bit mv [2][4][4];
   bit md [4][4];

   cache_line_state #(.WAYS(4), .TOTAL_SIZE(16), .INVAL_ON_FLUSH(1)) dut_a (
      .clk(clk), .rst(rst), .index(index), .way(way), .we(we),
      .set_dirty(set_dirty), .inv(inv), .clean(clean),
      .valid_out(a_valid), .dirty_out(a_dirty), .free_valid(a_fv),
      .free_way(a_fw), .set_full(a_full), .flush_req(flush_req),
      .flush_busy(a_busy), .flush_done(a_done), .wb_valid(a_wbv),
      .wb_way(a_wbw), .wb_index(a_wbi), .wb_ready(wb_ready));

   cache_line_state #(.WAYS(4), .TOTAL_SIZE(16), .INVAL_ON_FLUSH(0)) dut_b (
      .clk(clk), .rst(rst), .index(index), .way(way), .we(we),
      .set_dirty(set_dirty), .inv(inv), .clean(clean),
      .valid_out(b_valid), .dirty_out(b_dirty), .free_valid(b_fv),
      .free_way(b_fw), .set_full(b_full), .flush_req(flush_req),
      .flush_busy(b_busy), .flush_done(b_done), .wb_valid(b_wbv),
      .wb_way(b_wbw), .wb_index(b_wbi), .wb_ready(wb_ready));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] mvec(input int k, input int s);
      logic [3:0] r;
      for (int w = 0; w < 4; w++) r[w] = mv[k][s][w];
      return r;
   endfunction

   function automatic logic [3:0] dvec(input int s);
      logic [3:0] r;
      for (int w = 0; w < 4; w++) r[w] = md[s][w];
      return r;
   endfunction

   function automatic int mfree(input int k, input int s);
      for (int w = 0; w < 4; w++) if (!mv[k][s][w]) return w;
      return -1;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 4; w++) begin
            mv[0][s][w] = 0; mv[1][s][w] = 0; md[s][w] = 0;
         end
   endtask

   task automatic model_op(input int w, input int s, input bit f_we,
                           input bit f_sd, input bit f_inv, input bit f_cl);
      for (int k = 0; k < 2; k++) begin
         if (f_inv) begin
            mv[k][s][w] = 0; md[s][w] = 0;
         end else if (f_we) begin
            mv[k][s][w] = 1; md[s][w] = f_sd;
         end else if (f_cl) begin
            md[s][w] = 0;
         end
      end
   endtask

   task automatic idle_inputs();
      we = 0; set_dirty = 0; inv = 0; clean = 0;
      flush_req = 0; wb_ready = 0;
   endtask

   task automatic check_set(input int s);
      int fa, fb;
      index = 2'(s);
      #1;
      fa = mfree(0, s);
      fb = mfree(1, s);
      chk("valid_a", 32'(a_valid), 32'(mvec(0, s)));
      chk("valid_b", 32'(b_valid), 32'(mvec(1, s)));
      chk("dirty_a", 32'(a_dirty), 32'(dvec(s)));
      chk("dirty_b", 32'(b_dirty), 32'(dvec(s)));
      chk("free_valid_a", 32'(a_fv), 32'(fa >= 0));
      chk("free_valid_b", 32'(b_fv), 32'(fb >= 0));
      chk("free_way_a", 32'(a_fw), (fa < 0) ? 32'd0 : 32'(fa));
      chk("free_way_b", 32'(b_fw), (fb < 0) ? 32'd0 : 32'(fb));
      chk("set_full_a", 32'(a_full), 32'(fa < 0));
      chk("set_full_b", 32'(b_full), 32'(fb < 0));
   endtask

   task automatic check_all();
      for (int s = 0; s < 4; s++) check_set(s);
   endtask

   task automatic do_op(input int w, input int s, input bit f_we,
                        input bit f_sd, input bit f_inv, input bit f_cl);
      way = 2'(w); index = 2'(s);
      we = f_we; set_dirty = f_sd; inv = f_inv; clean = f_cl;
      @(posedge clk); #1;
      idle_inputs();
      model_op(w, s, f_we, f_sd, f_inv, f_cl);
   endtask

   task automatic pulse_reset();
      idle_inputs();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      model_clear();
   endtask

   // Optional fill (op_en) rides in the same cycle as flush_req.
   task automatic run_flush(input int stall_first, input bit rstall,
                            input bit op_en, input int ow, input int os,
                            input bit osd, output int busy_a);
      int q[$];
      int nq, stall, tot_stall, busy_b;
      bit done;
      way = 2'(ow); index = 2'(os);
      we = op_en; set_dirty = osd;
      flush_req = 1;
      @(posedge clk); #1;
      idle_inputs();
      if (op_en) model_op(ow, os, 1'b1, osd, 1'b0, 1'b0);
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 4; w++)
            if (md[s][w]) q.push_back(s * 4 + w);
      nq = q.size();
      stall = stall_first; tot_stall = 0;
      busy_a = 0; busy_b = 0; done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         wb_ready = 0;
         if (a_busy) busy_a++;
         if (b_busy) busy_b++;
         if (a_done) begin
            done = 1;
            chk("done_b", 32'(b_done), 32'd1);
            chk("wbv_at_done", 32'(a_wbv), 32'd0);
         end else begin
            if (a_wbv) begin
               chk("wbv_b", 32'(b_wbv), 32'd1);
               if (q.size() == 0) begin
                  chk("wb_unexpected", 32'(a_wbv), 32'd0);
               end else begin
                  chk("wb_way_a", 32'(a_wbw), 32'(q[0] % 4));
                  chk("wb_index_a", 32'(a_wbi), 32'(q[0] / 4));
                  chk("wb_way_b", 32'(b_wbw), 32'(q[0] % 4));
                  chk("wb_index_b", 32'(b_wbi), 32'(q[0] / 4));
               end
               if (stall > 0) begin
                  stall--; tot_stall++;
               end else begin
                  wb_ready = 1;
                  if (q.size() != 0) void'(q.pop_front());
                  stall = rstall ? $urandom_range(0, 2) : 0;
               end
            end else begin
               wb_ready = 1'($urandom_range(0, 1));
            end
            // ops and repeated requests while busy must be ignored
            way = 2'($urandom_range(0, 3));
            index = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            set_dirty = 1'($urandom_range(0, 1));
            inv = 1'($urandom_range(0, 1));
            clean = 1'($urandom_range(0, 1));
            flush_req = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
      end
      idle_inputs();
      chk("flush_finished", 32'(done), 32'd1);
      chk("offers_left", 32'(q.size()), 32'd0);
      chk("busy_cycles_a", 32'(busy_a), 32'(17 + nq + tot_stall));
      chk("busy_cycles_b", 32'(busy_b), 32'(17 + nq + tot_stall));
      @(posedge clk); #1;
      chk("idle_busy_a", 32'(a_busy), 32'd0);
      chk("idle_done_a", 32'(a_done), 32'd0);
      chk("idle_busy_b", 32'(b_busy), 32'd0);
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 4; w++) begin
            md[s][w] = 0; mv[0][s][w] = 0;
         end
      check_all();
   endtask

   initial begin
      int bc;
      bit seen;
      idle_inputs();
      index = 0; way = 0;
      rst = 1;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 0;

      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_wbv", 32'(a_wbv), 32'd0);
      chk("rst_wbw", 32'(a_wbw), 32'd0);
      chk("rst_wbi", 32'(a_wbi), 32'd0);
      check_all();

      do_op(2, 1, 1, 1, 0, 0);
      check_set(1);
      chk("t1_valid", 32'(a_valid), 32'h4);
      chk("t1_dirty", 32'(a_dirty), 32'h4);
      check_set(0);
      chk("t1_valid_set0", 32'(a_valid), 32'h0);

      do_op(0, 3, 1, 0, 0, 0);
      do_op(1, 3, 1, 1, 0, 0);
      do_op(3, 3, 1, 0, 0, 0);
      check_set(3);
      chk("t2_free_way", 32'(a_fw), 32'd2);
      do_op(2, 3, 1, 0, 0, 0);
      check_set(3);
      chk("t2_full", 32'(a_full), 32'd1);
      do_op(1, 3, 1, 1, 1, 0);
      check_set(3);
      chk("t2_inv_we", 32'(a_valid), 32'hD);
      do_op(0, 1, 0, 1, 0, 0);
      do_op(2, 1, 0, 0, 0, 1);
      check_set(1);

      pulse_reset();
      check_all();
      run_flush(0, 0, 0, 0, 0, 0, bc);
      chk("t3_busy17", 32'(bc), 32'd17);

      do_op(3, 0, 1, 1, 0, 0);
      do_op(0, 0, 1, 0, 0, 0);
      run_flush(5, 0, 1, 1, 2, 1, bc);
      chk("t4_busy", 32'(bc), 32'd24);
      check_set(0);
      chk("t5_kept_b", 32'(b_valid), 32'h9);
      chk("t4_clear_a", 32'(a_valid), 32'h0);

      do_op(3, 0, 1, 1, 0, 0);
      do_op(1, 2, 1, 1, 0, 0);
      way = 0; index = 0;
      flush_req = 1;
      @(posedge clk); #1;
      flush_req = 0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (a_wbv) seen = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("t6_reached_wb", 32'(seen), 32'd1);
      rst = 1;
      #1;
      chk("t6_wbv", 32'(a_wbv), 32'd0);
      chk("t6_busy", 32'(a_busy), 32'd0);
      chk("t6_busy_b", 32'(b_busy), 32'd0);
      model_clear();
      check_all();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("t6_no_done", 32'(a_done | b_done), 32'd0);
      end
      rst = 0;
      @(posedge clk); #1;
      chk("t6_no_done_post", 32'(a_done), 32'd0);
      do_op(0, 0, 1, 1, 0, 0);
      do_op(2, 1, 1, 1, 0, 0);
      run_flush(1, 0, 0, 0, 0, 0, bc);

      for (int n = 0; n < 240; n++) begin
         do_op($urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0));
         check_set($urandom_range(0, 3));
         if (n % 60 == 59)
            run_flush($urandom_range(0, 3), 1, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1, bc);
      end
      check_all();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
